// File: rtl/fwd_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit_if
//   Bundles the ID-stage operand request, the in-flight pipeline results and
//   the resolved operands/stall returned by fwd_hazard_unit.
//
//   master : the core side (drives ID/EX/MEM/WB information, reads results)
//   slave  : fwd_hazard_unit
//
//   id_valid, id_rs_addr, id_rs_used, id_rs_data, id_rd, id_wen, id_is_load,
//   flush, ex_result, mem_result, mem_ready, wb_data   : master -> slave
//   fwd_data, stall, perf_stall_cnt                    : slave -> master
// ---------------------------------------------------------------------------
interface fwd_hazard_unit_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int PERF_W  = 32
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs_addr;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [NUM_SRC*XLEN-1:0]   id_rs_data;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_wen;
  logic                      id_is_load;
  logic                      flush;
  logic [XLEN-1:0]           ex_result;
  logic [XLEN-1:0]           mem_result;
  logic                      mem_ready;
  logic [XLEN-1:0]           wb_data;
  logic [NUM_SRC*XLEN-1:0]   fwd_data;
  logic                      stall;
  logic [PERF_W-1:0]         perf_stall_cnt;

  modport master (
    output id_valid, id_rs_addr, id_rs_used, id_rs_data, id_rd, id_wen,
           id_is_load, flush, ex_result, mem_result, mem_ready, wb_data,
    input  fwd_data, stall, perf_stall_cnt
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rs_used, id_rs_data, id_rd, id_wen,
           id_is_load, flush, ex_result, mem_result, mem_ready, wb_data,
    output fwd_data, stall, perf_stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   Operand forwarding and hazard detection between ID and EX of a 5-stage
//   RISC-V pipeline. A shadow scoreboard (EX/MEM/WB records) tracks in-flight
//   destinations; each source operand is resolved to the youngest producer's
//   value in the same cycle. Stall is raised on load-use hazards and while a
//   load in MEM waits for data memory.
//
//   Ports
//     clk    : core clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : fwd_hazard_unit_if.slave (ID request, pipeline results,
//              fwd_data / stall / perf_stall_cnt)
//
//   Configuration macro
//     FWD_PERF_EN : when defined, perf_stall_cnt is a saturating count of
//                   stalled cycles; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int PERF_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_unit_if.slave   bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              is_load;
  } rec_t;

  localparam rec_t BUBBLE = '0;

  rec_t                    r_ex, r_mem, r_wb;
  rec_t                    w_id_rec;
  logic                    w_mem_wait;
  logic                    w_hazard;
  logic                    w_stall;
  logic [NUM_SRC-1:0]      w_op_hz;
  logic [NUM_SRC*XLEN-1:0] w_fwd_data;

  function automatic logic hit(input rec_t rec, input logic [REG_AW-1:0] addr);
    return rec.valid & rec.wen & (rec.rd == addr);
  endfunction

  assign w_mem_wait = r_mem.valid & r_mem.is_load & ~bus.mem_ready;

  // Priority chain: x0, EX, MEM, WB, register file. A load in EX, or a load
  // in MEM still waiting on memory, has no data yet: report a hazard and
  // drive zero rather than a stale value.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    w_fwd_data = '0;
    w_op_hz    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_rs_addr[i*REG_AW +: REG_AW] == '0) begin
        w_fwd_data[i*XLEN +: XLEN] = '0;
      end else if (hit(r_ex, bus.id_rs_addr[i*REG_AW +: REG_AW])) begin
        if (r_ex.is_load) w_op_hz[i] = 1'b1;
        else              w_fwd_data[i*XLEN +: XLEN] = bus.ex_result;
      end else if (hit(r_mem, bus.id_rs_addr[i*REG_AW +: REG_AW])) begin
        if (w_mem_wait) w_op_hz[i] = 1'b1;
        else            w_fwd_data[i*XLEN +: XLEN] = bus.mem_result;
      end else if (hit(r_wb, bus.id_rs_addr[i*REG_AW +: REG_AW])) begin
        w_fwd_data[i*XLEN +: XLEN] = bus.wb_data;
      end else begin
        w_fwd_data[i*XLEN +: XLEN] = bus.id_rs_data[i*XLEN +: XLEN];
      end
    end
  end

  // Unused operands are still resolved but never hold the pipeline.
  assign w_hazard = |(w_op_hz & bus.id_rs_used);
  assign w_stall  = bus.id_valid & ~bus.flush & (w_hazard | w_mem_wait);

  // Outputs are forced quiet while reset is asserted.
  assign bus.stall    = rst_n & w_stall;
  assign bus.fwd_data = rst_n ? w_fwd_data : '0;

  assign w_id_rec = '{valid: 1'b1, rd: bus.id_rd, wen: bus.id_wen,
                      is_load: bus.id_is_load};

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the three records are control state, not a storage array; they
    // must be reset so no phantom producer survives a reset.
    if (!rst_n) begin
      r_ex  <= BUBBLE;
      r_mem <= BUBBLE;
      r_wb  <= BUBBLE;
    end else if (w_mem_wait) begin
      // MEM and EX freeze behind the waiting load; WB drains to a bubble.
      // A redirect may still squash the instruction held in EX, never MEM.
      r_wb <= BUBBLE;
      if (bus.flush) r_ex <= BUBBLE;
    end else begin
      // NOTE: non-blocking assignments make the shift read the old values of
      // every stage, so WB<=MEM and MEM<=EX can be written in any order.
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= (bus.id_valid & ~w_stall & ~bus.flush) ? w_id_rec : BUBBLE;
    end
  end

`ifdef FWD_PERF_EN
  logic [PERF_W-1:0] r_perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_perf_cnt <= '0;
    else if (w_stall && (r_perf_cnt != '1)) r_perf_cnt <= r_perf_cnt + PERF_W'(1);
  end

  assign bus.perf_stall_cnt = r_perf_cnt;
`else
  assign bus.perf_stall_cnt = '0;
`endif

endmodule
